// File: rtl/script_sequencer.sv
// Script executor: fetches 16-bit instructions from an async ROM at pc and runs
// nop/action/jump/wait/halt, in free-run or single-step mode.
module script_sequencer #(
  parameter int PC_W     = 8,
  parameter int PC_STEP  = 2,
  parameter int FB_W     = 8,
  parameter int TICK_DIV = 16
) (
  input  logic            clk,
  input  logic            res,
  input  logic [15:0]     script,
  input  logic            run_mode,
  input  logic            step_pulse,
  input  logic [FB_W-1:0] feedback,
  input  logic            act_ready,
  output logic [PC_W-1:0] pc,
  output logic            act_valid,
  output logic [7:0]      act_target,
  output logic [1:0]      act_func,
  output logic            busy,
  output logic            done,
  output logic            err
);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_EXEC, S_ACT, S_WAIT, S_HALT, S_ERR
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;
  logic [7:0]      ticks_q, ticks_d;
  logic [TW-1:0]   tdiv_q, tdiv_d;
  logic            act_valid_q, act_valid_d;
  logic [7:0]      act_target_q, act_target_d;
  logic [1:0]      act_func_q, act_func_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic [7:0]       i_num;
  logic [2:0]       i_sign;
  logic [1:0]       func;
  logic [2:0]       op_code;
  logic [FB_W+7:0]  fb_ext;
  logic [PC_W+7:0]  tgt_ext;
  logic             fb_bit;
  logic [PC_W-1:0]  pc_inc, pc_tgt;

  assign i_num   = ir_q[15:8];
  assign i_sign  = ir_q[7:5];
  assign func    = ir_q[4:3];
  assign op_code = ir_q[2:0];
  // Zero padding makes out-of-range feedback indices read as 0 and widens i_num to pc.
  assign fb_ext  = {8'b0, feedback};
  assign tgt_ext = {{PC_W{1'b0}}, i_num};
  assign pc_tgt  = tgt_ext[PC_W-1:0];
  assign pc_inc  = pc_q + PC_W'(PC_STEP);

  always_comb begin
    fb_bit = 1'b0;
    for (int i = 0; i < 8; i++)
      if (i_sign == 3'(i)) fb_bit = fb_ext[i];
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    ticks_d      = ticks_q;
    tdiv_d       = tdiv_q;
    act_valid_d  = act_valid_q;
    act_target_d = act_target_q;
    act_func_d   = act_func_q;
    done_d       = done_q;
    err_d        = err_q;
    unique case (state_q)
      S_IDLE:  if (run_mode || step_pulse) state_d = S_FETCH;
      S_FETCH: begin
        ir_d    = script;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        unique case (op_code)
          3'b000: begin
            pc_d    = pc_inc;
            state_d = S_IDLE;
          end
          3'b001: begin
            act_valid_d  = 1'b1;
            act_target_d = i_num;
            act_func_d   = func;
            state_d      = S_ACT;
          end
          3'b010: begin
            state_d = S_IDLE;
            unique case (func)
              2'b00:   pc_d = pc_tgt;
              2'b01:   pc_d = fb_bit ? pc_tgt : pc_inc;
              2'b10:   pc_d = fb_bit ? pc_inc : pc_tgt;
              default: begin
                err_d   = 1'b1;
                state_d = S_ERR;
              end
            endcase
          end
          3'b011: begin
            ticks_d = i_num;
            tdiv_d  = TICK_LAST;
            if (func == 2'b11) begin
              err_d   = 1'b1;
              state_d = S_ERR;
            end else begin
              state_d = S_WAIT;
            end
          end
          3'b100: begin
            done_d  = 1'b1;
            state_d = S_HALT;
          end
          default: begin
            err_d   = 1'b1;
            state_d = S_ERR;
          end
        endcase
      end
      S_ACT: if (act_ready) begin
        act_valid_d = 1'b0;
        pc_d        = pc_inc;
        state_d     = S_IDLE;
      end
      S_WAIT: begin
        if (func == 2'b00) begin
          // Last cycle of the last tick retires the wait: exactly i_num*TICK_DIV cycles.
          if (ticks_q == 8'd0 || (ticks_q == 8'd1 && tdiv_q == '0)) begin
            pc_d    = pc_inc;
            state_d = S_IDLE;
          end else if (tdiv_q == '0) begin
            tdiv_d  = TICK_LAST;
            ticks_d = ticks_q - 8'd1;
          end else begin
            tdiv_d = tdiv_q - TW'(1);
          end
        end else if ((func == 2'b01) ? fb_bit : !fb_bit) begin
          pc_d    = pc_inc;
          state_d = S_IDLE;
        end
      end
      default: state_d = state_q;
    endcase
    busy_d = !(state_d inside {S_IDLE, S_HALT, S_ERR});
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      state_q      <= S_IDLE;
      pc_q         <= '0;
      ir_q         <= '0;
      ticks_q      <= '0;
      tdiv_q       <= '0;
      act_valid_q  <= 1'b0;
      act_target_q <= '0;
      act_func_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      ticks_q      <= ticks_d;
      tdiv_q       <= tdiv_d;
      act_valid_q  <= act_valid_d;
      act_target_q <= act_target_d;
      act_func_q   <= act_func_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign pc         = pc_q;
  assign act_valid  = act_valid_q;
  assign act_target = act_target_q;
  assign act_func   = act_func_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
endmodule

// File: tb/tb_script_sequencer.sv
// Bench for script_sequencer: single-instruction vector table with a scoreboard,
// plus hand-written multi-cycle sequences.
module tb_script_sequencer;
  logic        clk = 1'b0;
  logic        res = 1'b0;
  logic [15:0] script;
  logic        run_mode = 1'b0;
  logic        step_pulse = 1'b0;
  logic [7:0]  feedback = 8'h00;
  logic        act_ready = 1'b0;
  logic [7:0]  pc;
  logic        act_valid;
  logic [7:0]  act_target;
  logic [1:0]  act_func;
  logic        busy, done, err;

  logic [15:0] rom [256];
  assign script = rom[pc];

  script_sequencer #(.PC_W(8), .PC_STEP(2), .FB_W(8), .TICK_DIV(4)) dut (
    .clk(clk), .res(res), .script(script), .run_mode(run_mode),
    .step_pulse(step_pulse), .feedback(feedback), .act_ready(act_ready),
    .pc(pc), .act_valid(act_valid), .act_target(act_target), .act_func(act_func),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] instr;
    logic [7:0]  fb;
    logic        rdy;
    logic [7:0]  pc;
    logic        dn;
    logic        er;
  } vec_t;

  typedef struct {
    logic [7:0] pc;
    logic       dn;
    logic       er;
  } exp_t;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];

  function automatic logic [15:0] mk(input logic [2:0] op, input logic [1:0] f,
                                     input logic [2:0] s, input logic [7:0] n);
    return {n, s, f, op};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
  endtask

  task automatic do_reset();
    res = 1'b0;
    tick(2);
    res = 1'b1;
  endtask

  task automatic pulse();
    step_pulse = 1'b1;
    tick(1);
    step_pulse = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    chk({nm, "_timeout"}, 32'(ok), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       tbl[18];
    exp_t       e;
    logic [7:0] seen[$];
    logic [7:0] prev;
    int         cnt;
    bit         ok;

    tbl[0]  = '{mk(3'd0, 2'd0, 3'd0, 8'h00), 8'h00, 1'b0, 8'h02, 1'b0, 1'b0};
    tbl[1]  = '{mk(3'd2, 2'd0, 3'd0, 8'h10), 8'h00, 1'b0, 8'h10, 1'b0, 1'b0};
    tbl[2]  = '{mk(3'd2, 2'd1, 3'd3, 8'h10), 8'h08, 1'b0, 8'h10, 1'b0, 1'b0};
    tbl[3]  = '{mk(3'd2, 2'd1, 3'd3, 8'h10), 8'hF7, 1'b0, 8'h02, 1'b0, 1'b0};
    tbl[4]  = '{mk(3'd2, 2'd2, 3'd5, 8'h20), 8'hDF, 1'b0, 8'h20, 1'b0, 1'b0};
    tbl[5]  = '{mk(3'd2, 2'd2, 3'd5, 8'h20), 8'h20, 1'b0, 8'h02, 1'b0, 1'b0};
    tbl[6]  = '{mk(3'd2, 2'd3, 3'd0, 8'h10), 8'h00, 1'b0, 8'h00, 1'b0, 1'b1};
    tbl[7]  = '{mk(3'd3, 2'd0, 3'd0, 8'h00), 8'h00, 1'b0, 8'h02, 1'b0, 1'b0};
    tbl[8]  = '{mk(3'd3, 2'd1, 3'd0, 8'h00), 8'h01, 1'b0, 8'h02, 1'b0, 1'b0};
    tbl[9]  = '{mk(3'd3, 2'd2, 3'd0, 8'h00), 8'hFE, 1'b0, 8'h02, 1'b0, 1'b0};
    tbl[10] = '{mk(3'd3, 2'd3, 3'd0, 8'h01), 8'h00, 1'b0, 8'h00, 1'b0, 1'b1};
    tbl[11] = '{mk(3'd4, 2'd0, 3'd0, 8'h00), 8'h00, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[12] = '{mk(3'd5, 2'd0, 3'd0, 8'h00), 8'h00, 1'b0, 8'h00, 1'b0, 1'b1};
    tbl[13] = '{mk(3'd6, 2'd0, 3'd0, 8'h00), 8'h00, 1'b0, 8'h00, 1'b0, 1'b1};
    tbl[14] = '{mk(3'd7, 2'd0, 3'd0, 8'h00), 8'h00, 1'b0, 8'h00, 1'b0, 1'b1};
    tbl[15] = '{mk(3'd1, 2'd2, 3'd0, 8'h33), 8'h00, 1'b1, 8'h02, 1'b0, 1'b0};
    tbl[16] = '{mk(3'd3, 2'd0, 3'd0, 8'h02), 8'h00, 1'b0, 8'h02, 1'b0, 1'b0};
    tbl[17] = '{mk(3'd2, 2'd0, 3'd0, 8'hFF), 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0};

    // Free-run nop, nop, halt
    clear_rom();
    rom[4] = mk(3'd4, 2'd0, 3'd0, 8'h00);
    run_mode = 1'b1;
    do_reset();
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_act_valid", 32'(act_valid), 32'h0);
    seen.push_back(pc);
    prev = pc;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (pc != prev) seen.push_back(pc);
      prev = pc;
    end
    chk("run_npcs", 32'(seen.size()), 32'd3);
    chk("run_pc1", 32'(seen[1]), 32'h2);
    chk("run_pc2", 32'(seen[2]), 32'h4);
    chk("run_done", 32'(done), 32'h1);
    tick(10);
    chk("run_done_sticky", 32'(done), 32'h1);
    chk("run_pc_frozen", 32'(pc), 32'h4);
    run_mode = 1'b0;

    // Single-instruction table, stepped
    for (int k = 0; k < 18; k++) begin
      clear_rom();
      rom[0] = tbl[k].instr;
      do_reset();
      feedback  = tbl[k].fb;
      act_ready = tbl[k].rdy;
      sb.push_back('{tbl[k].pc, tbl[k].dn, tbl[k].er});
      pulse();
      wait_idle($sformatf("vec%0d", k));
      e = sb.pop_front();
      chk($sformatf("vec%0d_pc", k), 32'(pc), 32'(e.pc));
      chk($sformatf("vec%0d_done", k), 32'(done), 32'(e.dn));
      chk($sformatf("vec%0d_err", k), 32'(err), 32'(e.er));
      act_ready = 1'b0;
      feedback  = 8'h00;
    end

    // Action held until act_ready
    clear_rom();
    rom[0] = mk(3'd1, 2'd1, 3'd0, 8'h05);
    do_reset();
    pulse();
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (act_valid) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    chk("act_seen", 32'(ok), 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("act_hold_valid", 32'(act_valid), 32'h1);
      chk("act_hold_target", 32'(act_target), 32'h05);
      chk("act_hold_func", 32'(act_func), 32'h1);
      chk("act_hold_pc", 32'(pc), 32'h0);
      tick(1);
    end
    act_ready = 1'b1;
    tick(1);
    act_ready = 1'b0;
    chk("act_done_valid", 32'(act_valid), 32'h0);
    chk("act_done_pc", 32'(pc), 32'h2);
    act_ready = 1'b1;
    tick(3);
    act_ready = 1'b0;
    chk("act_idle_ready_pc", 32'(pc), 32'h2);

    // Timed wait 3 ticks of 4 cycles, then reset mid-wait
    clear_rom();
    rom[0] = mk(3'd3, 2'd0, 3'd0, 8'h03);
    rom[2] = mk(3'd3, 2'd0, 3'd0, 8'h03);
    do_reset();
    pulse();
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (!busy) break;
      cnt++;
      tick(1);
    end
    chk("wait_busy_cycles", 32'(cnt), 32'd14);
    chk("wait_pc", 32'(pc), 32'h2);
    pulse();
    tick(5);
    chk("wait_mid_busy", 32'(busy), 32'h1);
    res = 1'b0;
    tick(1);
    res = 1'b1;
    chk("wait_rst_pc", 32'(pc), 32'h0);
    chk("wait_rst_busy", 32'(busy), 32'h0);
    tick(3);
    chk("wait_rst_stays_idle", 32'(busy), 32'h0);

    // Single-step: no progress without pulse, busy pulses dropped
    clear_rom();
    do_reset();
    tick(10);
    chk("step_nopulse_pc", 32'(pc), 32'h0);
    pulse();
    wait_idle("step1");
    chk("step1_pc", 32'(pc), 32'h2);
    pulse();
    pulse();
    wait_idle("step2");
    tick(10);
    chk("step_busy_pulse_pc", 32'(pc), 32'h4);

    // Error is sticky even in free-run
    clear_rom();
    rom[0] = mk(3'd7, 2'd0, 3'd0, 8'h00);
    do_reset();
    pulse();
    wait_idle("err");
    run_mode = 1'b1;
    pulse();
    tick(10);
    run_mode = 1'b0;
    chk("err_sticky", 32'(err), 32'h1);
    chk("err_pc_frozen", 32'(pc), 32'h0);
    chk("err_busy", 32'(busy), 32'h0);

    // pc wrap from 0xFE
    clear_rom();
    rom[0] = mk(3'd2, 2'd0, 3'd0, 8'hFE);
    do_reset();
    pulse();
    wait_idle("wrap_jump");
    chk("wrap_jump_pc", 32'(pc), 32'hFE);
    pulse();
    wait_idle("wrap_nop");
    chk("wrap_pc", 32'(pc), 32'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
